// File: rtl/modulo_gerenciador_rolhas_param.sv
// Cork buffer manager: loads corks into a secondary buffer and automatically
// refills the primary buffer from it while corks are consumed one per cycle.
module modulo_gerenciador_rolhas_param #(
   parameter int W       = 7,
   parameter int CAP_SEC = 99,
   parameter int CAP_PRI = 99,
   parameter int MIN_PRI = 5,
   parameter int REFILL  = 20
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load_req,
   input  logic [W-1:0] load_qty,
   input  logic         auto_en,
   input  logic         use_rolha,
   output logic [W-1:0] primario,
   output logic [W-1:0] secundario,
   output logic         load_ack,
   output logic         load_err,
   output logic         ro,
   output logic         min_flag,
   output logic         busy,
   output logic [1:0]   estado
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      XFER = 2'b10
   } state_t;

   localparam logic [W:0] CAP_SEC_X = (W+1)'(CAP_SEC);
   localparam logic [W:0] CAP_PRI_X = (W+1)'(CAP_PRI);
   localparam logic [W:0] MIN_PRI_X = (W+1)'(MIN_PRI);
   localparam logic [W:0] REFILL_X  = (W+1)'(REFILL);

   state_t       state;
   logic [W-1:0] rem;

   logic [W:0]   load_sum;
   logic [W:0]   pri_room;
   logic [W:0]   refill_amt;
   logic         start_xfer;
   logic         pri_inc;
   logic         pri_dec;
   logic [W-1:0] pri_next;

   // Widened by one bit so sums and differences can never wrap before comparing.
   always_comb begin
      load_sum   = {1'b0, secundario} + {1'b0, load_qty};
      pri_room   = CAP_PRI_X - {1'b0, primario};
      refill_amt = REFILL_X;
      if ({1'b0, secundario} < refill_amt) refill_amt = {1'b0, secundario};
      if (pri_room < refill_amt) refill_amt = pri_room;
      start_xfer = auto_en && ({1'b0, primario} < MIN_PRI_X) && (secundario != '0);

      // A refill step and a consumed cork on the same edge cancel out; an empty
      // primary cannot be consumed from, so it still gains the refilled cork.
      pri_inc  = (state == XFER) && (rem != '0);
      pri_dec  = use_rolha && (primario != '0);
      pri_next = primario;
      if (pri_inc && !pri_dec)
         pri_next = primario + W'(1);
      else if (!pri_inc && pri_dec)
         pri_next = primario - W'(1);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state      <= IDLE;
         rem        <= '0;
         primario   <= '0;
         secundario <= '0;
         load_ack   <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         load_ack <= 1'b0;
         load_err <= 1'b0;
         primario <= pri_next;
         case (state)
            IDLE: begin
               if (load_req) begin
                  if (load_sum <= CAP_SEC_X) begin
                     rem   <= load_qty;
                     state <= LOAD;
                  end else begin
                     load_err <= 1'b1;
                  end
               end else if (start_xfer) begin
                  rem   <= refill_amt[W-1:0];
                  state <= XFER;
               end
            end
            LOAD: begin
               if (rem != '0) begin
                  secundario <= secundario + W'(1);
                  rem        <= rem - W'(1);
               end else begin
                  state    <= IDLE;
                  load_ack <= 1'b1;
               end
            end
            XFER: begin
               if (rem != '0) begin
                  secundario <= secundario - W'(1);
                  rem        <= rem - W'(1);
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ro       = (primario == '0);
   assign min_flag = ({1'b0, primario} < MIN_PRI_X);
   assign busy     = (state != IDLE);
   assign estado   = state;

endmodule

// File: tb/tb_modulo_gerenciador_rolhas_param.sv
// Bench for the cork buffer manager: directed scenarios plus random traffic,
// compared every cycle against a counts-and-jobs reference model.
module tb_modulo_gerenciador_rolhas_param;

   localparam int W       = 7;
   localparam int CAP_SEC = 99;
   localparam int CAP_PRI = 99;
   localparam int MIN_PRI = 5;
   localparam int REFILL  = 20;

   logic         clk = 1'b0;
   logic         clr;
   logic         load_req;
   logic [W-1:0] load_qty;
   logic         auto_en;
   logic         use_rolha;
   logic [W-1:0] primario;
   logic [W-1:0] secundario;
   logic         load_ack;
   logic         load_err;
   logic         ro;
   logic         min_flag;
   logic         busy;
   logic [1:0]   estado;

   int total = 0;
   int bad   = 0;
   int ack_seen = 0;
   int acks_before;

   // Reference model: plain integer counts and the job in progress.
   bit model_valid = 1'b0;
   int m_pri, m_sec, m_job, m_left;
   bit m_ack, m_err;

   modulo_gerenciador_rolhas_param #(
      .W(W), .CAP_SEC(CAP_SEC), .CAP_PRI(CAP_PRI), .MIN_PRI(MIN_PRI), .REFILL(REFILL)
   ) dut (
      .clk(clk), .clr(clr), .load_req(load_req), .load_qty(load_qty),
      .auto_en(auto_en), .use_rolha(use_rolha), .primario(primario),
      .secundario(secundario), .load_ack(load_ack), .load_err(load_err),
      .ro(ro), .min_flag(min_flag), .busy(busy), .estado(estado)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit lr, input int qty, input bit ae, input bit use_c,
                                input bit rst, input int cycles);
      load_req  = lr;
      load_qty  = W'(qty);
      auto_en   = ae;
      use_rolha = use_c;
      clr       = rst;
      repeat (cycles) @(negedge clk);
   endtask

   // Model update from the inputs present at each rising edge.
   always @(posedge clk) begin
      int pri_before, amount;
      bit consume;
      if (clr) begin
         model_valid = 1'b1;
         m_pri = 0; m_sec = 0; m_job = 0; m_left = 0; m_ack = 0; m_err = 0;
      end else if (model_valid) begin
         pri_before = m_pri;
         consume = use_rolha && (pri_before > 0);
         m_ack = 0;
         m_err = 0;
         if (m_job == 0) begin
            if (load_req) begin
               if (m_sec + int'(load_qty) <= CAP_SEC) begin
                  m_job = 1; m_left = int'(load_qty);
               end else begin
                  m_err = 1;
               end
            end else if (auto_en && pri_before < MIN_PRI && m_sec > 0) begin
               amount = REFILL;
               if (m_sec < amount) amount = m_sec;
               if (CAP_PRI - pri_before < amount) amount = CAP_PRI - pri_before;
               m_job = 2; m_left = amount;
            end
         end else if (m_job == 1) begin
            if (m_left > 0) begin m_sec++; m_left--; end
            else begin m_job = 0; m_ack = 1; end
         end else begin
            if (m_left > 0) begin m_sec--; m_pri++; m_left--; end
            else m_job = 0;
         end
         if (consume) m_pri--;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (model_valid) begin
         checkOutput("primario", int'(primario), m_pri);
         checkOutput("secundario", int'(secundario), m_sec);
         checkOutput("load_ack", int'(load_ack), int'(m_ack));
         checkOutput("load_err", int'(load_err), int'(m_err));
         checkOutput("ro", int'(ro), int'(m_pri == 0));
         checkOutput("min_flag", int'(min_flag), int'(m_pri < MIN_PRI));
         checkOutput("busy", int'(busy), int'(m_job != 0));
         checkOutput("estado", int'(estado), m_job);
         checkOutput("ack_err_exclusive", int'(load_ack & load_err), 0);
         if (load_ack) ack_seen++;
      end
   end

   initial begin
      int qty;
      applyStimulus(0, 0, 0, 0, 1, 2);

      // Reset state.
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("rst_ro", int'(ro), 1);
      checkOutput("rst_min_flag", int'(min_flag), 1);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_estado", int'(estado), 0);

      // Basic load of 20.
      acks_before = ack_seen;
      applyStimulus(1, 20, 0, 0, 0, 1);
      checkOutput("load_estado", int'(estado), 1);
      applyStimulus(0, 0, 0, 0, 0, 24);
      checkOutput("load20_sec", int'(secundario), 20);
      checkOutput("load20_acks", ack_seen - acks_before, 1);
      checkOutput("load20_estado", int'(estado), 0);

      // Fill to 90, reject 10, accept 9.
      applyStimulus(1, 70, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 75);
      checkOutput("fill90_sec", int'(secundario), 90);
      applyStimulus(1, 10, 0, 0, 0, 1);
      checkOutput("ovf_err", int'(load_err), 1);
      checkOutput("ovf_sec", int'(secundario), 90);
      checkOutput("ovf_estado", int'(estado), 0);
      applyStimulus(0, 0, 0, 0, 0, 2);
      checkOutput("ovf_err_pulse", int'(load_err), 0);
      applyStimulus(1, 9, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 12);
      checkOutput("fill99_sec", int'(secundario), 99);

      // Automatic refill from secundario=50, primario=0.
      applyStimulus(0, 0, 0, 0, 1, 1);
      applyStimulus(1, 50, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 55);
      applyStimulus(0, 0, 1, 0, 0, 1);
      checkOutput("xfer_estado", int'(estado), 2);
      checkOutput("xfer_ro_before", int'(ro), 1);
      applyStimulus(0, 0, 1, 0, 0, 1);
      checkOutput("xfer_ro_after", int'(ro), 0);
      applyStimulus(0, 0, 1, 0, 0, 24);
      checkOutput("xfer_pri", int'(primario), 20);
      checkOutput("xfer_sec", int'(secundario), 30);
      checkOutput("xfer_idle", int'(estado), 0);

      // Refill limited by stock: secundario=3, primario=2.
      applyStimulus(0, 0, 0, 0, 1, 1);
      applyStimulus(1, 5, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 8);
      applyStimulus(0, 0, 1, 0, 0, 10);
      applyStimulus(0, 0, 0, 1, 0, 3);
      checkOutput("stock_pri_pre", int'(primario), 2);
      applyStimulus(1, 3, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 6);
      checkOutput("stock_sec_pre", int'(secundario), 3);
      applyStimulus(0, 0, 1, 0, 0, 8);
      checkOutput("stock_pri", int'(primario), 5);
      checkOutput("stock_sec", int'(secundario), 0);
      checkOutput("stock_min_flag", int'(min_flag), 0);
      checkOutput("stock_estado", int'(estado), 0);

      // Consumption during a 20-cork refill from primario=4.
      applyStimulus(0, 0, 0, 1, 0, 1);
      applyStimulus(1, 30, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 33);
      applyStimulus(0, 0, 1, 0, 0, 1);
      checkOutput("cons_start_pri", int'(primario), 4);
      applyStimulus(0, 0, 1, 1, 0, 20);
      checkOutput("cons_pri", int'(primario), 4);
      checkOutput("cons_sec", int'(secundario), 10);
      applyStimulus(0, 0, 0, 0, 0, 3);

      // Reset in the middle of a load.
      acks_before = ack_seen;
      applyStimulus(1, 20, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 4);
      applyStimulus(0, 0, 0, 0, 1, 1);
      checkOutput("midrst_pri", int'(primario), 0);
      checkOutput("midrst_sec", int'(secundario), 0);
      checkOutput("midrst_estado", int'(estado), 0);
      applyStimulus(0, 0, 0, 0, 0, 25);
      checkOutput("midrst_no_ack", ack_seen - acks_before, 0);
      applyStimulus(0, 0, 0, 1, 0, 3);
      checkOutput("empty_use_pri", int'(primario), 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         qty = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 30));
         applyStimulus($urandom_range(0, 3) == 0, qty, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0, 1);
      end
      applyStimulus(0, 0, 0, 0, 0, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
